// File: rtl/sad_block_accumulator.sv
// Sum-of-absolute-differences accumulator: adds the four nibble lanes of each
// input beat, accumulates them over a block and hands one result per block downstream.
module sad_block_accumulator #(
  parameter int BLOCK_LEN = 16,
  parameter int SUM_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_diff,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat;

  logic [5:0]       lane_sum;
  logic [SUM_W:0]   acc_wide;
  logic [SUM_W-1:0] acc_next;
  logic             sat_next;
  logic             accept;
  logic             close_block;

  // One extra carry bit on the accumulator add detects overflow so it can clamp.
  always_comb begin
    lane_sum = {2'b00, in_diff[3:0]}  + {2'b00, in_diff[7:4]} +
               {2'b00, in_diff[11:8]} + {2'b00, in_diff[15:12]};
    acc_wide = {1'b0, acc} + {{(SUM_W-5){1'b0}}, lane_sum};
    acc_next = acc_wide[SUM_W] ? {SUM_W{1'b1}} : acc_wide[SUM_W-1:0];
    sat_next = sat | acc_wide[SUM_W];
  end

  assign in_ready    = rst_n && (state == ACCUM);
  assign out_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign close_block = accept && (in_last || (count == CNT_W'(BLOCK_LEN - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close_block) begin
            out_sum   <= acc_next;
            out_beats <= count + CNT_W'(1);
            out_sat   <= sat_next;
            acc       <= '0;
            count     <= '0;
            sat       <= 1'b0;
            state     <= HOLD;
          end else if (accept) begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            sat   <= sat_next;
          end
        end
        // The handshake edge only releases the result; input resumes next cycle.
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Self-checking bench: a BLOCK_LEN=4 instance tracked by a cycle model and scoreboard,
// plus a SUM_W=8 instance exercising saturation.
module tb_sad_block_accumulator;

  localparam int BL_A   = 4;
  localparam int MAX_A  = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_diff;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_sum;
  logic [7:0]  out_beats;

  logic        b_in_valid, b_in_last, b_out_ready;
  logic [15:0] b_in_diff;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [7:0]  b_out_sum;
  logic [7:0]  b_out_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_block_accumulator #(.BLOCK_LEN(BL_A), .SUM_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats), .out_sat(out_sat)
  );

  sad_block_accumulator #(.BLOCK_LEN(5), .SUM_W(8), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_diff(b_in_diff), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_beats(b_out_beats), .out_sat(b_out_sat)
  );

  typedef struct {
    int sum;
    int beats;
    int sat;
  } result_t;

  typedef struct {
    logic [15:0] diff;
    int          exp_sum;
  } vec_t;

  result_t exp_q[$];
  bit      m_hold = 1'b0;
  int      m_acc = 0, m_cnt = 0, m_sat = 0;

  function automatic int lanes(input logic [15:0] d);
    return int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of instance A; results enter the scoreboard on the closing beat.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_sat = 0;
      exp_q.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (in_valid) begin
      m_acc += lanes(in_diff);
      if (m_acc > MAX_A) begin
        m_acc = MAX_A;
        m_sat = 1;
      end
      m_cnt++;
      if (in_last || m_cnt == BL_A) begin
        exp_q.push_back('{m_acc, m_cnt, m_sat});
        m_hold = 1'b1; m_acc = 0; m_cnt = 0; m_sat = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      checkOutput("mon_in_ready", int'(in_ready), int'(rst_n && !m_hold));
      checkOutput("mon_out_valid", int'(out_valid), int'(m_hold));
      if (m_hold && exp_q.size() > 0) begin
        checkOutput("mon_out_sum", int'(out_sum), exp_q[0].sum);
        checkOutput("mon_out_beats", int'(out_beats), exp_q[0].beats);
        checkOutput("mon_out_sat", int'(out_sat), exp_q[0].sat);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic last);
    in_valid = 1'b1; in_diff = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_diff = 16'($urandom); in_last = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("after_hs_valid", int'(out_valid), 0);
  endtask

  task automatic expectResult(input string name, input int s, input int b, input int st);
    checkOutput({name, "_valid"}, int'(out_valid), 1);
    checkOutput({name, "_sum"}, int'(out_sum), s);
    checkOutput({name, "_beats"}, int'(out_beats), b);
    checkOutput({name, "_sat"}, int'(out_sat), st);
  endtask

  task automatic applyStimulusSat(input logic [15:0] d, input logic last);
    b_in_valid = 1'b1; b_in_diff = d; b_in_last = last;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h1234, 10};
    vecs[1] = '{16'hFFFF, 60};
    vecs[2] = '{16'h0000, 0};
    vecs[3] = '{16'h8421, 15};
    vecs[4] = '{16'hF0F0, 30};
    vecs[5] = '{16'h9999, 36};

    rst_n = 1'b0; in_valid = 1'b0; in_diff = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_diff = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    idle(3);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sum", int'(out_sum), 0);
    checkOutput("reset_out_beats", int'(out_beats), 0);
    checkOutput("reset_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("post_reset_in_ready", int'(in_ready), 1);

    $display("[TB] single-beat table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].diff, 1'b1);
      expectResult($sformatf("vec%0d", i), vecs[i].exp_sum, 1, 0);
      handshake();
    end

    $display("[TB] full block back-to-back");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(16'hFFFF, 1'b0);
    expectResult("full", 240, 4, 0);
    checkOutput("full_in_ready_hold", int'(in_ready), 0);
    in_valid = 1'b1; in_diff = 16'h0011; in_last = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_cycle_no_accept", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expectResult("next_block", 2, 1, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] backpressure");
    applyStimulus(16'h1111, 1'b0);
    applyStimulus(16'h1111, 1'b1);
    in_valid = 1'b1; in_diff = 16'h2222; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expectResult("bp_stable", 8, 2, 0);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expectResult("bp_new_block", 8, 1, 0);
    handshake();

    $display("[TB] gapped input");
    applyStimulus(16'h0101, 1'b0);
    idle(3);
    applyStimulus(16'h0202, 1'b0);
    idle(1);
    applyStimulus(16'h0303, 1'b1);
    expectResult("gapped", 12, 3, 0);
    handshake();

    $display("[TB] reset mid-block and in hold");
    applyStimulus(16'h4444, 1'b0);
    applyStimulus(16'h4444, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    applyStimulus(16'h0005, 1'b1);
    expectResult("rst_mid", 5, 1, 0);
    rst_n = 1'b0;
    idle(1);
    checkOutput("rst_hold_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("rst_hold_in_ready", int'(in_ready), 1);

    $display("[TB] saturation instance");
    for (int i = 0; i < 5; i++) applyStimulusSat(16'hFFFF, 1'b0);
    checkOutput("sat_valid", int'(b_out_valid), 1);
    checkOutput("sat_sum", int'(b_out_sum), 255);
    checkOutput("sat_beats", int'(b_out_beats), 5);
    checkOutput("sat_flag", int'(b_out_sat), 1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    applyStimulusSat(16'h0001, 1'b1);
    checkOutput("sat_clear_sum", int'(b_out_sum), 1);
    checkOutput("sat_clear_beats", int'(b_out_beats), 1);
    checkOutput("sat_clear_flag", int'(b_out_sat), 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
